// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry add/subtract unit.
// The WIDTH-bit operation is split into STAGES = WIDTH/SEG segments. Stage k
// adds segment k and registers its carry for stage k+1, so one carry-chain
// segment sits between each pair of registers. Operands and already-computed
// low result segments travel alongside in skew registers so that every slot
// of the pipe holds one complete, coherent operation.
//
// Handshake (valid/ready):
//   - An operation is accepted on a rising edge where in_valid & in_ready.
//   - A result is consumed on a rising edge where out_valid & out_ready.
//   - in_ready is combinational: adv = ~out_valid | out_ready. The whole pipe
//     either advances together (adv = 1) or holds together (adv = 0), so a
//     stalled result keeps sum/cout/ovf/out_valid stable and blocks intake.
//   - Consuming a result and accepting a new op in the same cycle is allowed
//     and inserts no bubble; bubbles (in_valid = 0) travel as empty slots.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    // Pipe advance enable shared by every stage.
    logic adv;

    // Subtraction is a + ~b + ~cin, so both inversions happen before stage 0.
    logic [WIDTH-1:0] eb_in;
    logic             c0;

    // Stage registers: operand A, effective B, partial result, carry, valid.
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] eb_q [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             v_q  [STAGES];

    // What each stage sees as its input: the unit inputs for stage 0, the
    // previous stage's registers otherwise.
    logic [WIDTH-1:0] a_src  [STAGES];
    logic [WIDTH-1:0] eb_src [STAGES];
    logic [WIDTH-1:0] s_src  [STAGES];
    logic             c_src  [STAGES];
    logic             v_src  [STAGES];

    // Values each stage will load on the next advancing edge.
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_nxt [STAGES];

    // Form effective B and the stage-0 carry from the add/sub mode.
    always_comb begin
        eb_in = sub ? ~b : b;
        c0    = sub ? ~cin : cin;
    end

    // Route each stage's inputs: unit inputs into stage 0, stage k-1 into k.
    always_comb begin
        a_src[0]  = a;
        eb_src[0] = eb_in;
        s_src[0]  = '0;
        c_src[0]  = c0;
        v_src[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]  = a_q[k-1];
            eb_src[k] = eb_q[k-1];
            s_src[k]  = s_q[k-1];
            c_src[k]  = c_q[k-1];
            v_src[k]  = v_q[k-1];
        end
    end

    // Per-stage segment adder: stage k fills in result segment k and
    // produces the carry that stage k+1 consumes.
    always_comb begin
        logic [SEG:0] seg_sum;
        seg_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k] = s_src[k];
            seg_sum  = {1'b0, a_src[k][k*SEG +: SEG]}
                     + {1'b0, eb_src[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_src[k]};
            s_nxt[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            c_nxt[k] = seg_sum[SEG];
        end
    end

    // Stage registers: async clear discards in-flight work; all stages move
    // together on adv and hold together otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                eb_q[k] <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                v_q[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_src[k];
                eb_q[k] <= eb_src[k];
                s_q[k]  <= s_nxt[k];
                c_q[k]  <= c_nxt[k];
                v_q[k]  <= v_src[k];
            end
        end
    end

    // Output side: the last stage holds the finished operation. Signed
    // overflow needs only the registered MSBs of A, effective B and the sum;
    // with everything cleared on reset it evaluates to 0 as well.
    always_comb begin
        out_valid = v_q[LAST];
        sum       = s_q[LAST];
        cout      = c_q[LAST];
        ovf       = (a_q[LAST][MSB] == eb_q[LAST][MSB]) &&
                    (s_q[LAST][MSB] != a_q[LAST][MSB]);
        adv       = ~v_q[LAST] | out_ready;
        in_ready  = adv;
    end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed checks of pipe_adder (WIDTH=16, SEG=4) plus a
// latency/result sweep of the SEG=16 and SEG=1 configurations against a
// reference model of a +/- b +/- cin.
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    // SEG=4 instance (4 stages)
    logic        in_ready;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    // SEG=16 instance (1 stage)
    logic        in_ready_s16;
    logic        out_valid_s16;
    logic [15:0] sum_s16;
    logic        cout_s16;
    logic        ovf_s16;

    // SEG=1 instance (16 stages)
    logic        in_ready_s1;
    logic        out_valid_s1;
    logic [15:0] sum_s1;
    logic        cout_s1;
    logic        ovf_s1;

    int n_tests;
    int n_fail;

    logic [17:0] exp_q[$];

    logic        hv   [256];
    logic [17:0] hexp [256];

    logic [15:0] va [8] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0005,
                            16'h8000, 16'h0FFF, 16'h1234, 16'hABCD};
    logic [15:0] vb [8] = '{16'h0002, 16'h0001, 16'h0001, 16'h0007,
                            16'h0001, 16'h0000, 16'h4321, 16'h1111};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    pipe_adder #(.WIDTH(16), .SEG(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipe_adder #(.WIDTH(16), .SEG(16)) u_dut_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s16),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_s16),
        .out_ready(out_ready), .sum(sum_s16), .cout(cout_s16), .ovf(ovf_s16)
    );

    pipe_adder #(.WIDTH(16), .SEG(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_s1),
        .out_ready(out_ready), .sum(sum_s1), .cout(cout_s1), .ovf(ovf_s1)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] eb;
        logic        c0;
        logic [16:0] t;
        logic        o;
        eb = ms ? ~mb : mb;
        c0 = ms ? ~mc : mc;
        t  = {1'b0, ma} + {1'b0, eb} + {16'b0, c0};
        o  = (ma[15] == eb[15]) && (t[15] != ma[15]);
        return {o, t[16], t[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1; measure latency and check the result.
    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_single(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                              input logic tc, input logic ts, input logic [17:0] exp_r);
        int lat;
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 4);
        check({tag, "_result"}, {14'b0, ovf, cout, sum}, {14'b0, exp_r});
        @(posedge clk); #1;
    endtask

    // Sweep check for one instance of latency lat at sample cycle c.
    task automatic check_sweep(input string tag, input int lat, input int c, input logic ov,
                               input logic o_ovf, input logic o_cout, input logic [15:0] o_sum);
        if (c >= lat && hv[c-lat])
            check(tag, {13'b0, ov, o_ovf, o_cout, o_sum}, {13'b0, 1'b1, hexp[c-lat]});
        else
            check({tag, "_idle"}, 32'(ov), 0);
    endtask

    initial begin
        int idx;
        int got;
        int n_stall;
        int seen;
        logic        have_hold;
        logic [18:0] held;
        logic [18:0] cur;
        logic [17:0] e;

        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout_ovf", {30'b0, cout, ovf}, 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Directed single operations, hand-computed {ovf, cout, sum}
        run_single("ffff_plus_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        run_single("7fff_plus_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        run_single("5_minus_7",    16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        run_single("8000_minus_1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        run_single("0fff_ripple",  16'h0FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1000});
        run_single("ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b0, 1'b1, 16'hFFFF});
        run_single("0_minus_0_b1", 16'h0000, 16'h0000, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFF});
        run_single("1234_4321",    16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});

        // Back-to-back stream with a 3-cycle consumer stall
        idx = 0; got = 0; n_stall = 0; have_hold = 1'b0; held = '0;
        exp_q.delete();
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 5 && c < 8);
            in_valid = (idx < 8);
            if (idx < 8) begin
                a = va[idx]; b = vb[idx]; cin = vc[idx]; sub = vs[idx];
            end
            @(negedge clk);
            cur = {out_valid, ovf, cout, sum};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("b2b_extra", 32'(out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("b2b_result", {14'b0, ovf, cout, sum}, {14'b0, e});
                    got++;
                end
                have_hold = 1'b0;
            end else if (out_valid) begin
                n_stall++;
                check("stall_in_ready", 32'(in_ready), 0);
                if (have_hold) begin
                    check("stall_hold", {13'b0, cur}, {13'b0, held});
                end else begin
                    held = cur;
                    have_hold = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                idx++;
            end
            @(posedge clk); #1;
            if (idx == 8 && got == 8) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("b2b_count", 32'(got), 8);
        check("b2b_leftover", 32'(exp_q.size()), 0);
        check("b2b_stall_cycles", 32'(n_stall), 3);

        // Reset mid-flight: two ops in the pipe, the first stalled at output
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h2222; b = 16'h0101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_valid", {15'b0, out_valid, sum}, {15'b0, 1'b1, 16'h2345});
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_sum", 32'(sum), 0);
        check("mid_rst_cout_ovf", {30'b0, cout, ovf}, 0);
        out_ready = 1'b1;
        #6 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_no_stale", 32'(seen), 0);
        @(posedge clk); #1;
        run_single("post_rst_op", 16'h00FF, 16'h0F01, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});

        // Sweep: random stream into all three configurations
        in_valid = 1'b0;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 220; c++) begin
            out_ready = 1'b1;
            in_valid = (c < 200) && ($urandom_range(0, 7) != 0);
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            hv[c] = in_valid;
            hexp[c] = model(a, b, cin, sub);
            @(negedge clk);
            check_sweep("sweep_seg4", 4, c, out_valid, ovf, cout, sum);
            check_sweep("sweep_seg16", 1, c, out_valid_s16, ovf_s16, cout_s16, sum_s16);
            check_sweep("sweep_seg1", 16, c, out_valid_s1, ovf_s1, cout_s1, sum_s1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry add/subtract unit; the next generation of the team's single-bit full adder.
- The operand is split into WIDTH/SEG segments. Each segment is added in its own register stage, and the carry is chained between stages.
- It accepts one operation per cycle under a valid/ready handshake and reports carry/borrow and signed overflow.
- It is the arithmetic building block for the lab datapath (accumulators, ALU).

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).
- SEG, 4, bits per pipeline stage. Must divide WIDTH. STAGES = WIDTH/SEG sets the latency.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/mode valid this cycle
- in_ready  output  1  unit can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  add: carry out of MSB; sub: 1 = no borrow, 0 = borrow
- ovf  output  1  signed (two's-complement) overflow

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, sum, cout and ovf go to 0 immediately. In-flight operations are discarded, not completed. in_ready becomes 1 after reset release.
- Arithmetic:
  - Effective B: eb = sub ? ~b : b.
  - Stage-0 carry-in: c0 = sub ? ~cin : cin.
  - Result: {cout, sum} = a + eb + c0.
  - Overflow: ovf = (a[MSB] == eb[MSB]) && (sum[MSB] != a[MSB]).
- Stage k (0..STAGES-1):
  - Registers segment k of sum using a[k*SEG +: SEG], eb segment and the carry registered by stage k-1 (c0 for k = 0).
  - Lower result segments and upper operand segments travel alongside in skew registers, so each operation stays coherent.
- Valids: each stage has one valid bit. The last stage drives out_valid, sum, cout and ovf. ovf is computed in the last stage from the registered MSB operand bits.
- Advance: adv = ~out_valid | out_ready. When adv = 1, every stage loads from its predecessor and stage 0 loads the inputs; stage-0 valid = in_valid. When adv = 0, all stages hold.
- Handshake: in_ready = adv (combinational). An operation is accepted when in_valid & in_ready.
- Latency and throughput:
  - The result appears with out_valid = 1 exactly STAGES cycles after acceptance when never stalled.
  - Throughput is 1 op/cycle; order is preserved.
  - Bubbles (in_valid = 0) propagate as invalid slots and are not compressed.
- Output stability: while out_valid & ~out_ready, sum/cout/ovf/out_valid hold stable and in_ready = 0.
- Simultaneous events: out_ready and a new in_valid in the same cycle means the output is consumed and the new op is accepted in that same cycle; no bubble is inserted.
- Degenerate case SEG = WIDTH: STAGES = 1, latency 1 cycle; behaviour otherwise identical.
- Wrap-around: results are modulo 2^WIDTH. The carry chain crosses every segment boundary correctly, e.g. 0x0FFF+1 ripples through 3 segments.

Test Plan:
- WIDTH=16, SEG=4; a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> exactly 4 cycles later: out_valid=1, sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Carry ripple: a=0x0FFF, b=0x0000, cin=1, sub=0 -> sum=0x1000, cout=0. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Back-to-back: 8 ops issued on consecutive cycles, out_ready held low for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 8 results returned in order with none lost or duplicated. Compare against a reference model.
- Reset mid-flight: 2 ops in the pipe, then rst_n pulsed low asynchronously (off clock edge) -> out_valid/sum/cout/ovf = 0 immediately, no stale result after release, and the next op completes normally after 4 cycles.
- Parameter sweep: SEG=16 (STAGES=1) and SEG=1 (STAGES=16) with exhaustive random a/b/cin/sub -> latency equals STAGES and results match the reference model.
